// File: rtl/fib_pkg.sv
// Shared types and default sizing for the Fibonacci step arbiter.
// Imported by the interface, datapath and top.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic {
    OP_P1,
    OP_P2
  } op_t;

  localparam int W_DEF     = 11;
  localparam int BOUND_DEF = 300;
  localparam int CW_DEF    = 8;

endpackage

// File: rtl/fib_step_arbiter_if.sv
// Handshake and status bundle between a step sequencer and its user.
// master drives start/req; slave returns grants, status and datapath.
interface fib_step_arbiter_if #(
  parameter int W  = fib_pkg::W_DEF,
  parameter int CW = fib_pkg::CW_DEF
);

  logic          start;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          busy;
  logic          done;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [W-1:0]  i;
  logic [W-1:0]  j;
  logic [CW-1:0] step_cnt;
  logic          inv_err;

  modport master (
    output start, req,
    input  gnt, busy, done,
    input  x, y, i, j,
    input  step_cnt, inv_err
  );

  modport slave (
    input  start, req,
    output gnt, busy, done,
    output x, y, i, j,
    output step_cnt, inv_err
  );

endinterface

// File: rtl/fib_step_datapath.sv
// Accumulator registers x, y, i, j and their one-step update.
// All right-hand sides use pre-step values; wraps modulo 2^W.
module fib_step_datapath
  import fib_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         step_en,
  input  op_t          op,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] i,
  output logic [W-1:0] j
);

  logic [W-1:0] j_inc;

  // j grows by y+1 for a +1 step and by y+2 for a +2 step
  always_comb begin
    j_inc = W'(1);
    if (op == OP_P2) j_inc = W'(2);
  end

  // clear on reset or new run, otherwise advance one step when granted
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x <= '0;
      y <= '0;
      i <= '0;
      j <= '0;
    end else if (step_en) begin
      x <= x + W'(1);
      y <= y + W'(1);
      i <= i + x + W'(1);
      j <= j + y + j_inc;
    end
  end

endmodule

// File: rtl/fib_step_arbiter.sv
// Round-robin arbiter sequencing a bounded Fibonacci-style run.
// Holds the run FSM, grant logic, step counter and j>=i monitor.
module fib_step_arbiter
  import fib_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int BOUND = BOUND_DEF,
  parameter int CW    = CW_DEF
) (
  input logic               clk,
  input logic               rst,
  fib_step_arbiter_if.slave bus
);

  localparam logic [W-1:0]  BND = W'(BOUND);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  state_t        state;
  logic          rr;
  logic [CW-1:0] step_cnt;
  logic          inv_err;
  logic [1:0]    gnt;
  logic          clr;
  logic          step_en;
  logic          at_bound;
  op_t           op;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [W-1:0]  i;
  logic [W-1:0]  j;

  assign at_bound = (j >= BND);
  assign clr      = bus.start && (state != RUN);
  assign step_en  = |gnt;

  // grant at most one requester; rr=1 means req1 is favoured
  always_comb begin
    gnt = 2'b00;
    if (state == RUN && !at_bound) begin
      if (bus.req == 2'b11) gnt = rr ? 2'b10 : 2'b01;
      else                  gnt = bus.req;
    end
  end

  // req1 issues the +2 step, req0 the +1 step
  always_comb begin
    op = OP_P1;
    if (gnt[1]) op = OP_P2;
  end

  fib_step_datapath #(
    .W(W)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .step_en (step_en),
    .op      (op),
    .x       (x),
    .y       (y),
    .i       (i),
    .j       (j)
  );

  // run FSM, round-robin pointer, step counter and invariant flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr       <= 1'b0;
      step_cnt <= '0;
      inv_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= RUN;
            rr       <= 1'b0;
            step_cnt <= '0;
          end
        end
        RUN: begin
          if (at_bound) begin
            state <= DONE;
          end else if (step_en) begin
            rr <= gnt[0];
            if (step_cnt != CMAX)
              step_cnt <= step_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if (clr)
        inv_err <= 1'b0;
      else if (state != IDLE && j < i)
        inv_err <= 1'b1;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.x        = x;
  assign bus.y        = y;
  assign bus.i        = i;
  assign bus.j        = j;
  assign bus.step_cnt = step_cnt;
  assign bus.inv_err  = inv_err;

endmodule

// File: tb/tb_fib_step_arbiter.sv
// Directed plus random checks of fib_step_arbiter against a
// cycle-level arithmetic model of a bounded run.
module tb_fib_step_arbiter;

  localparam int W     = 11;
  localparam int BOUND = 300;
  localparam int CW    = 8;
  localparam int MASK  = (1 << W) - 1;
  localparam int CSAT  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fib_step_arbiter_if #(.W(W), .CW(CW)) bus ();

  fib_step_arbiter #(
    .W(W), .BOUND(BOUND), .CW(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model: phase 0 idle, 1 running, 2 finished
  int mph  = 0;
  int mfav = 0;
  int mx   = 0;
  int my   = 0;
  int mi   = 0;
  int mj   = 0;
  int mc   = 0;
  int minv = 0;

  int ngr = 0;
  int ng0 = 0;
  int ng1 = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_gnt(input logic [1:0] r);
    if (mph != 1 || mj >= BOUND) return 0;
    if (r == 2'b11) return (mfav == 0) ? 1 : 2;
    return int'(r);
  endfunction

  task automatic model_edge(input logic s, input logic rs,
                            input int g);
    if (rs) begin
      mph = 0; mfav = 0; minv = 0;
      mx = 0; my = 0; mi = 0; mj = 0; mc = 0;
    end else if (s && mph != 1) begin
      mph = 1; mfav = 0; minv = 0;
      mx = 0; my = 0; mi = 0; mj = 0; mc = 0;
    end else if (mph == 1) begin
      if (mj < mi) minv = 1;
      if (mj >= BOUND) begin
        mph = 2;
      end else if (g != 0) begin
        mi = (mi + mx + 1) & MASK;
        mj = (mj + my + ((g == 2) ? 2 : 1)) & MASK;
        mx = (mx + 1) & MASK;
        my = (my + 1) & MASK;
        if (mc < CSAT) mc++;
        mfav = (g == 1) ? 1 : 0;
      end
    end else if (mph == 2) begin
      if (mj < mi) minv = 1;
    end
  endtask

  task automatic check_all();
    check("x", bus.x, mx);
    check("y", bus.y, my);
    check("i", bus.i, mi);
    check("j", bus.j, mj);
    check("step_cnt", bus.step_cnt, mc);
    check("busy", bus.busy, mph == 1);
    check("done", bus.done, mph == 2);
    check("inv_err", bus.inv_err, minv);
  endtask

  task automatic tick(input logic s, input logic [1:0] r,
                      input logic rs);
    int eg;
    @(negedge clk);
    bus.start = s;
    bus.req   = r;
    rst       = rs;
    #1;
    eg = model_gnt(r);
    check("gnt", bus.gnt, eg);
    if (eg != 0) ngr++;
    if (eg == 1) ng0++;
    if (eg == 2) ng1++;
    @(posedge clk);
    model_edge(s, rs, eg);
    #1;
    check_all();
  endtask

  task automatic begin_run();
    ngr = 0; ng0 = 0; ng1 = 0;
    tick(1'b1, 2'b00, 1'b0);
  endtask

  task automatic run_to_done(input logic [1:0] r);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      tick(1'b0, r, 1'b0);
      n++;
    end
    check("run_done", bus.done, 1);
  endtask

  initial begin
    int jh;
    bus.start = 1'b0;
    bus.req   = 2'b00;

    tick(1'b0, 2'b00, 1'b1);
    check("rst_gnt", bus.gnt, 0);
    check("rst_j", bus.j, 0);
    tick(1'b0, 2'b11, 1'b0);

    begin_run();
    check("start_busy", bus.busy, 1);
    run_to_done(2'b01);
    check("p1_grants", ngr, 24);
    check("p1_x", bus.x, 24);
    check("p1_y", bus.y, 24);
    check("p1_i", bus.i, 300);
    check("p1_j", bus.j, 300);
    check("p1_cnt", bus.step_cnt, 24);
    check("p1_inv", bus.inv_err, 0);

    begin_run();
    run_to_done(2'b10);
    check("p2_grants", ngr, 24);
    check("p2_x", bus.x, 24);
    check("p2_i", bus.i, 300);
    check("p2_j", bus.j, 324);

    begin_run();
    run_to_done(2'b11);
    check("rr_g0", ng0, 12);
    check("rr_g1", ng1, 12);
    check("rr_i", bus.i, 300);
    check("rr_j", bus.j, 312);
    check("rr_cnt", bus.step_cnt, 24);

    begin_run();
    repeat (5) tick(1'b0, 2'b01, 1'b0);
    jh = int'(bus.j);
    repeat (5) tick(1'b0, 2'b00, 1'b0);
    check("gap_j", bus.j, jh);
    check("gap_cnt", bus.step_cnt, 5);
    run_to_done(2'b01);
    check("gap_final_j", bus.j, 300);

    begin_run();
    repeat (10) tick(1'b0, 2'b01, 1'b0);
    check("pre_rst_cnt", bus.step_cnt, 10);
    tick(1'b0, 2'b01, 1'b1);
    check("mid_rst_x", bus.x, 0);
    check("mid_rst_j", bus.j, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_gnt", bus.gnt, 0);
    begin_run();
    run_to_done(2'b01);
    check("rerun_j", bus.j, 300);

    begin_run();
    repeat (5) tick(1'b0, 2'b01, 1'b0);
    tick(1'b1, 2'b01, 1'b0);
    check("start_in_run_cnt", bus.step_cnt, 6);
    run_to_done(2'b01);
    check("start_in_run_grants", ngr, 24);
    check("start_in_run_j", bus.j, 300);

    for (int k = 0; k < 4; k++) begin
      begin_run();
      for (int c = 0; c < 120; c++) begin
        tick(($urandom_range(0, 15) == 0),
             2'($urandom_range(0, 3)), 1'b0);
      end
    end
    run_to_done(2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fib_step_arbiter.md
# fib_step_arbiter

Shares one Fibonacci-style accumulator datapath (x, y, i, j) between two step requesters and sequences a bounded run of it. Requester 0 issues "+1" steps and requester 1 issues "+2" steps, and each grant advances the datapath by exactly one step. The block clears the datapath on start and stops granting once j reaches the bound. It also reports done and step count, and carries a sticky j≥i invariant monitor for formal and sim checks.

## Interface
Parameters:
- W, 11, width of x, y, i, j
- BOUND, 300, run stops when j ≥ BOUND; legal range 1..2^(W-1)-1
- CW, 8, width of step_cnt

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin new run; honoured in IDLE or DONE, ignored in RUN
- req  in  2  step requests; req[0] = sel-1 step, req[1] = sel-0 step; held until granted
- gnt  out  2  one-hot-or-zero grant, combinational from req and state
- busy  out  1  state == RUN
- done  out  1  state == DONE
- x, y, i, j  out  W each  datapath registers
- step_cnt  out  CW  steps executed this run, saturating at 2^CW-1
- inv_err  out  1  sticky flag, set if j < i ever observed in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start → x, y, i, j, step_cnt, inv_err cleared at that edge.
  - RR pointer set to req0.
  - Next state RUN.
- RUN, j ≥ BOUND:
  - gnt = 0.
  - Next state DONE.
- RUN, j < BOUND:
  - Grant one requester.
  - Both requesting → grant the one the RR pointer favours; the pointer moves to the other after each grant.
  - Single requester → that requester is granted every cycle.
  - No requests → idle cycle with no datapath change.
- Step effects, applied at the edge where gnt is asserted:
  - gnt[0] (sel=1): x+=1, y+=1, i+=x+1, j+=y+1.
  - gnt[1] (sel=0): x+=1, y+=1, i+=x+1, j+=y+2.
  - Right-hand sides use pre-step values. Arithmetic is modulo 2^W.
  - step_cnt increments.
- DONE:
  - Datapath and step_cnt hold; gnt = 0.
  - start → clear and go to RUN, same as from IDLE.
- inv_err: set on any cycle in RUN/DONE with j < i. Cleared only by rst or start. It never sets in a correct implementation.
- Reset values: state IDLE; x = y = i = j = 0; step_cnt = 0; gnt = 0; busy = done = inv_err = 0; RR pointer favours req0.

## Timing
- start sampled at edge E0 → busy = 1 from E0+1; the first grant is possible in the cycle after E0.
- Grant and update are same-cycle: gnt is high in cycle c, and registers change at the end of c. The requester must drop or re-arm req after seeing gnt.
- The last step lands at edge En. The cycle after En is one RUN cycle with gnt = 0. done = 1 from En+2.
- Rst has priority over everything. rst mid-RUN → all outputs return to reset values at the next edge, and any pending req is lost.
- start and rst in the same cycle → rst wins.
- start while RUN → no effect.

## Structure
- Package fib_pkg:
  - state enum {IDLE, RUN, DONE}.
  - step-op typedef {OP_P1, OP_P2}.
  - Default W and BOUND constants.
- Sub-module fib_step_datapath:
  - Inputs: clk, rst, clr, step_en, op.
  - Outputs: x, y, i, j.
  - Holds the registers and step arithmetic.
- The arbiter, FSM, counter and monitor live in the top module.

## Test plan
- req=2'b01 held after start → exactly 24 grants; final x = y = 24, i = j = 300, step_cnt = 24, done = 1, inv_err = 0.
- req=2'b10 held → 24 grants; final x = 24, i = 300, j = 324, done = 1.
- req=2'b11 held → alternating gnt 01, 10, 01, …; 12 grants each; final i = 300, j = 312, step_cnt = 24.
- req=0 for 5 cycles mid-run, then 2'b01 → no state change during the gap; the run still completes with j = 300.
- rst asserted after 10 steps → next cycle all outputs are 0 and state is IDLE; start then re-runs to j = 300.
- start pulsed during RUN → ignored. start in DONE → registers cleared and a new run of 24 steps completes.
